// File: rtl/sevenseg_scan_ctl_pkg.sv
// sevenseg_pkg: shared constants for the seven-segment scan controller.
//   - Code word layout (7 bits): bit 6 = blank, bit 5 = dp, bit 4 = dash,
//     bits 3:0 = hex value.
//   - CODE_BLANK / CODE_DASH: canonical code words.
//   - HEX_GLYPH: active-high segment patterns, bit order {a,b,c,d,e,f,g}
//     (bit 6 = segment a, bit 0 = segment g).
package sevenseg_pkg;

    localparam int CODE_W   = 7;
    localparam int BLANK_BIT = 6;
    localparam int DP_BIT    = 5;
    localparam int DASH_BIT  = 4;

    localparam logic [CODE_W-1:0] CODE_BLANK = 7'b1000000;
    localparam logic [CODE_W-1:0] CODE_DASH  = 7'b0010000;

    // Active-low segment pattern for the dash glyph (segment g only lit).
    localparam logic [6:0] SEG_DASH_N = 7'b1111110;

    // Entry 15 is listed first (packed array concatenation order).
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
        7'h1F, 7'h77, 7'h7B, 7'h7F,   // b A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

endpackage

// File: rtl/sevenseg_scan_ctl_if.sv
// sevenseg_scan_ctl_if: write-side bus of the scan controller.
//   wr_en / wr_addr / wr_data : single-cycle write into the shadow bank.
//   commit                    : request a shadow->active copy at the next
//                               frame boundary.
// Strobe semantics: every signal is sampled on each rising clock edge; a
// write or commit is one cycle of the strobe high, there is no ready/back-
// pressure, so the producer may issue one write per cycle indefinitely.
// master drives the bus, slave (the controller) observes it.
interface sevenseg_scan_ctl_if
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS = 8
);
    localparam int AW = $clog2(NUM_DIGITS);

    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CODE_W-1:0] wr_data;
    logic              commit;

    modport master (output wr_en, wr_addr, wr_data, commit);
    modport slave  (input  wr_en, wr_addr, wr_data, commit);

endinterface

// File: rtl/sevenseg_ext.sv
// sevenseg_ext: combinational decode of one code word to active-low pins.
//   code_i   : 7-bit code (blank / dp / dash / hex)
//   segs_n_o : active-low segments, bit 6 = a ... bit 0 = g
//   dp_n_o   : active-low decimal point
// Blank overrides everything; dash overrides the hex glyph but keeps dp.
module sevenseg_ext
    import sevenseg_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        segs_n_o,
    output logic              dp_n_o
);

    always_comb begin
        segs_n_o = 7'h7F;
        dp_n_o   = 1'b1;
        if (!code_i[BLANK_BIT]) begin
            dp_n_o = ~code_i[DP_BIT];
            if (code_i[DASH_BIT]) begin
                segs_n_o = SEG_DASH_N;
            end else begin
                segs_n_o = ~HEX_GLYPH[code_i[3:0]];
            end
        end
    end

endmodule

// File: rtl/sevenseg_scan_ctl.sv
// sevenseg_scan_ctl: multiplexed seven-segment display scanner with a
// double-buffered (shadow/active) digit bank.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en/wr_addr/
//   wr_data         : write one code into the shadow bank
//   commit          : copy shadow -> active at the next frame boundary
//   digit_en        : per-digit anode enable mask
//   an_n            : active-low anodes (registered)
//   segs_n, dp_n    : active-low segments / dp (decode of registered code)
//   frame_done      : one-cycle pulse during the frame-boundary cycle
//   commit_pending  : a commit is waiting for its frame boundary
// Each slot is SLOT_CYCLES long; the first BLANK_CYCLES keep every anode off
// to hide ghosting while segments switch.
module sevenseg_scan_ctl
    import sevenseg_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [CODE_W-1:0]             wr_data,
    input  logic                          commit,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic [6:0]                    segs_n,
    output logic                          dp_n,
    output logic                          frame_done,
    output logic                          commit_pending
);

    localparam int AW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SLOT_CYCLES);

    logic [CW-1:0]     slot_q,  slot_d;
    logic [AW-1:0]     digit_q, digit_d;
    logic [CODE_W-1:0] shadow_q [NUM_DIGITS];
    logic [CODE_W-1:0] shadow_d [NUM_DIGITS];
    logic [CODE_W-1:0] active_q [NUM_DIGITS];
    logic [CODE_W-1:0] active_d [NUM_DIGITS];
    logic              pending_q, pending_d;
    logic              frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
    logic [CODE_W-1:0] code_q, code_d;

    logic slot_wrap;
    logic last_digit;
    logic boundary;
    logic addr_ok;

    assign slot_wrap  = (slot_q == CW'(SLOT_CYCLES - 1));
    assign last_digit = (digit_q == AW'(NUM_DIGITS - 1));
    assign boundary   = slot_wrap && last_digit;
    assign addr_ok    = (32'(wr_addr) < NUM_DIGITS);

    always_comb begin
        slot_d  = slot_wrap ? '0 : slot_q + CW'(1);
        digit_d = digit_q;
        if (slot_wrap) begin
            digit_d = last_digit ? '0 : digit_q + AW'(1);
        end

        // Copy uses the registered shadow, so a same-cycle write only
        // reaches the shadow bank.
        active_d = active_q;
        if (boundary && pending_q) begin
            active_d = shadow_q;
        end

        shadow_d = shadow_q;
        if (wr_en && addr_ok) begin
            shadow_d[wr_addr] = wr_data;
        end

        // A commit arriving on the boundary itself survives the clear and
        // waits for the following boundary.
        pending_d = pending_q;
        if (boundary) begin
            pending_d = 1'b0;
        end
        if (commit) begin
            pending_d = 1'b1;
        end

        // Outputs are registered from the next-state counters so they line
        // up with slot_q/digit_q; code comes from active_d so digit 0 of a
        // new frame already shows the freshly copied bank.
        an_n_d = '1;
        if ((slot_d >= CW'(BLANK_CYCLES)) && digit_en[digit_d]) begin
            an_n_d[digit_d] = 1'b0;
        end
        code_d = active_d[digit_d];

        frame_done_d = (slot_d == CW'(SLOT_CYCLES - 1)) &&
                       (digit_d == AW'(NUM_DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= '0;
            digit_q      <= '0;
            shadow_q     <= '{default: CODE_BLANK};
            active_q     <= '{default: CODE_BLANK};
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            an_n_q       <= '1;
            code_q       <= CODE_BLANK;
        end else begin
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            an_n_q       <= an_n_d;
            code_q       <= code_d;
        end
    end

    sevenseg_ext u_decode (
        .code_i   (code_q),
        .segs_n_o (segs_n),
        .dp_n_o   (dp_n)
    );

    assign an_n           = an_n_q;
    assign frame_done     = frame_done_q;
    assign commit_pending = pending_q;

endmodule

// File: tb/tb_sevenseg_scan_ctl.sv
module tb_sevenseg_scan_ctl;

    localparam int ND = 4;
    localparam int SC = 8;
    localparam int BC = 2;

    logic       clk;
    logic       rst;
    logic [3:0] digit_en;
    logic [3:0] an_n;
    logic [6:0] segs_n;
    logic       dp_n;
    logic       frame_done;
    logic       commit_pending;

    int tests;
    int fails;
    int cyc;

    sevenseg_scan_ctl_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_ctl #(
        .NUM_DIGITS   (ND),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (bus.wr_en),
        .wr_addr        (bus.wr_addr),
        .wr_data        (bus.wr_data),
        .commit         (bus.commit),
        .digit_en       (digit_en),
        .an_n           (an_n),
        .segs_n         (segs_n),
        .dp_n           (dp_n),
        .frame_done     (frame_done),
        .commit_pending (commit_pending)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d expected finish before time limit", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [6:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic do_commit();
        bus.commit = 1'b1;
        tick();
        bus.commit = 1'b0;
    endtask

    // expected anode pattern for cycle c of a frame-aligned scan
    function automatic logic [3:0] exp_an(input int c, input logic [3:0] en);
        int pos;
        int d;
        logic [3:0] r;
        pos = c % SC;
        d   = (c / SC) % ND;
        r   = 4'hF;
        if (pos >= BC && en[d]) r[d] = 1'b0;
        return r;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL reset_an_n got=%h exp=f", an_n); end
        tests++; if (segs_n !== 7'h7F) begin fails++; $display("FAIL reset_segs_n got=%h exp=7f", segs_n); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL reset_dp_n got=%b exp=1", dp_n); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        tests++; if (commit_pending !== 1'b0) begin fails++; $display("FAIL reset_commit_pending got=%b exp=0", commit_pending); end
    endtask

    task automatic test_scan();
        while (cyc < 64) begin
            tests++;
            if (an_n !== exp_an(cyc, 4'hF)) begin
                fails++; $display("FAIL scan_an_n cyc=%0d got=%h exp=%h", cyc, an_n, exp_an(cyc, 4'hF));
            end
            tests++;
            if (frame_done !== ((cyc % 32) == 31)) begin
                fails++; $display("FAIL scan_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, (cyc % 32) == 31);
            end
            tests++;
            if (segs_n !== 7'h7F) begin
                fails++; $display("FAIL scan_blank_segs cyc=%0d got=%h exp=7f", cyc, segs_n);
            end
            tick();
        end
    endtask

    task automatic test_shadow_commit();
        wait_to(64);
        do_write(2'd1, 7'h05);
        do_commit();
        tests++; if (commit_pending !== 1'b1) begin fails++; $display("FAIL commit_pending_set got=%b exp=1", commit_pending); end
        wait_to(76);
        tests++; if (segs_n !== 7'h7F) begin fails++; $display("FAIL shadow_not_live got=%h exp=7f", segs_n); end
        wait_to(95);
        tests++; if (commit_pending !== 1'b1) begin fails++; $display("FAIL pending_held got=%b exp=1", commit_pending); end
        wait_to(96);
        tests++; if (commit_pending !== 1'b0) begin fails++; $display("FAIL pending_cleared got=%b exp=0", commit_pending); end
        wait_to(108);
        tests++; if (an_n !== 4'hD) begin fails++; $display("FAIL digit1_an_n got=%h exp=d", an_n); end
        tests++; if (segs_n !== 7'h24) begin fails++; $display("FAIL digit1_five got=%h exp=24", segs_n); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL digit1_dp got=%b exp=1", dp_n); end
    endtask

    task automatic test_same_cycle_copy();
        wait_to(100);
        do_write(2'd2, 7'h03);
        do_commit();
        wait_to(127);
        do_write(2'd2, 7'h28);   // lands during the copy edge
        wait_to(148);
        tests++; if (segs_n !== 7'h06) begin fails++; $display("FAIL copy_pre_write got=%h exp=06", segs_n); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL copy_pre_write_dp got=%b exp=1", dp_n); end
        wait_to(180);
        tests++; if (segs_n !== 7'h06) begin fails++; $display("FAIL no_commit_keeps got=%h exp=06", segs_n); end
        wait_to(192);
        do_commit();
        wait_to(212);
        tests++; if (segs_n !== 7'h06) begin fails++; $display("FAIL commit_waits_frame got=%h exp=06", segs_n); end
    endtask

    task automatic test_commit_at_boundary();
        wait_to(223);
        do_commit();
        tests++; if (commit_pending !== 1'b1) begin fails++; $display("FAIL boundary_commit_kept got=%b exp=1", commit_pending); end
        wait_to(244);
        tests++; if (segs_n !== 7'h00) begin fails++; $display("FAIL digit2_eight got=%h exp=00", segs_n); end
        tests++; if (dp_n !== 1'b0) begin fails++; $display("FAIL digit2_dp got=%b exp=0", dp_n); end
        wait_to(256);
        tests++; if (commit_pending !== 1'b0) begin fails++; $display("FAIL boundary_commit_done got=%b exp=0", commit_pending); end
    endtask

    task automatic test_decode();
        wait_to(256);
        do_write(2'd0, 7'h10);
        do_write(2'd3, 7'h7A);
        do_write(2'd1, 7'h0A);
        do_commit();
        wait_to(292);
        tests++; if (segs_n !== 7'b1111110) begin fails++; $display("FAIL dash_segs got=%h exp=7e", segs_n); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL dash_dp got=%b exp=1", dp_n); end
        wait_to(300);
        tests++; if (segs_n !== 7'h08) begin fails++; $display("FAIL hex_a_segs got=%h exp=08", segs_n); end
        wait_to(308);
        tests++; if (segs_n !== 7'h00) begin fails++; $display("FAIL digit2_persist got=%h exp=00", segs_n); end
        tests++; if (dp_n !== 1'b0) begin fails++; $display("FAIL digit2_persist_dp got=%b exp=0", dp_n); end
        wait_to(316);
        tests++; if (segs_n !== 7'h7F) begin fails++; $display("FAIL blank_override_segs got=%h exp=7f", segs_n); end
        tests++; if (dp_n !== 1'b1) begin fails++; $display("FAIL blank_override_dp got=%b exp=1", dp_n); end
    endtask

    task automatic test_digit_en();
        wait_to(319);
        digit_en = 4'b1011;
        while (cyc < 383) begin
            tick();
            tests++;
            if (an_n !== exp_an(cyc, 4'b1011)) begin
                fails++; $display("FAIL mask_an_n cyc=%0d got=%h exp=%h", cyc, an_n, exp_an(cyc, 4'b1011));
            end
            tests++;
            if (frame_done !== ((cyc % 32) == 31)) begin
                fails++; $display("FAIL mask_frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, (cyc % 32) == 31);
            end
        end
        digit_en = 4'hF;
    endtask

    task automatic test_reset_mid();
        wait_to(384);
        do_write(2'd0, 7'h03);
        do_commit();
        tests++; if (commit_pending !== 1'b1) begin fails++; $display("FAIL pre_reset_pending got=%b exp=1", commit_pending); end
        wait_to(403);
        tests++; if (an_n !== 4'hB) begin fails++; $display("FAIL pre_reset_an_n got=%h exp=b", an_n); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL mid_reset_an_n got=%h exp=f", an_n); end
        tests++; if (commit_pending !== 1'b0) begin fails++; $display("FAIL mid_reset_pending got=%b exp=0", commit_pending); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL mid_reset_frame_done got=%b exp=0", frame_done); end
        tests++; if (segs_n !== 7'h7F) begin fails++; $display("FAIL mid_reset_segs got=%h exp=7f", segs_n); end
        cyc = 0;
        while (cyc < 63) begin
            tick();
            tests++;
            if (an_n !== exp_an(cyc, 4'hF)) begin
                fails++; $display("FAIL restart_an_n cyc=%0d got=%h exp=%h", cyc, an_n, exp_an(cyc, 4'hF));
            end
            tests++;
            if (segs_n !== 7'h7F || dp_n !== 1'b1) begin
                fails++; $display("FAIL restart_blank cyc=%0d got=%h/%b exp=7f/1", cyc, segs_n, dp_n);
            end
        end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst         = 1'b1;
        digit_en    = 4'hF;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.commit  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;

        test_reset();
        test_scan();
        test_shadow_commit();
        test_same_cycle_copy();
        test_commit_at_boundary();
        test_decode();
        test_digit_en();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan_ctl.md
SEVENSEG_SCAN_CTL -- requirements
Module: sevenseg_scan_ctl

Interface
REQ-001 The module SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (2..8).
REQ-002 The module SHALL have parameter SLOT_CYCLES, default 100000, giving the clock cycles per digit slot.
REQ-003 The module SHALL have parameter BLANK_CYCLES, default 1000, giving the anode-off cycles at the start of each slot; it SHALL satisfy 1 <= BLANK_CYCLES < SLOT_CYCLES.
REQ-004 The module SHALL have port clk, input, 1 bit: the single system clock.
REQ-005 The module SHALL have port rst, input, 1 bit: reset; it SHALL be synchronous and active-high.
REQ-006 The module SHALL have port wr_en, input, 1 bit: a write strobe into the shadow bank.
REQ-007 The module SHALL have port wr_addr, input, $clog2(NUM_DIGITS) bits: the shadow digit index.
REQ-008 The module SHALL have port wr_data, input, 7 bits: the digit code, with bit 6 = blank, bit 5 = dp, bit 4 = dash, and bits 3:0 = hex.
REQ-009 The module SHALL have port commit, input, 1 bit: a request to copy shadow to active at the next frame boundary.
REQ-010 The module SHALL have port digit_en, input, NUM_DIGITS bits: a per-digit anode enable mask.
REQ-011 The module SHALL have port an_n, output, NUM_DIGITS bits: active-low anodes.
REQ-012 The module SHALL have port segs_n, output, 7 bits: active-low segments a..g.
REQ-013 The module SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-014 The module SHALL have port frame_done, output, 1 bit: a one-cycle pulse at each frame boundary.
REQ-015 The module SHALL have port commit_pending, output, 1 bit: high while a commit is awaiting its frame boundary.

Function
REQ-016 The slot counter SHALL count 0..SLOT_CYCLES-1 and wrap to 0; the digit index SHALL advance on that wrap, going 0..NUM_DIGITS-1 and then back to 0.
REQ-017 During slot-counter values 0..BLANK_CYCLES-1, an_n SHALL be all ones.
REQ-018 During the remainder of each slot, only an_n[digit] SHALL be 0, and only if digit_en[digit]=1; otherwise all anodes SHALL stay 1 and slot timing SHALL be unchanged.
REQ-019 an_n and the registered current code SHALL update on the same clock edge; segs_n and dp_n SHALL be a combinational decode of the registered code, so anodes and segments are never misaligned.
REQ-020 Decode: code bit 6 set SHALL force segs_n=7'h7F and dp_n=1.
REQ-021 Decode: otherwise dp_n SHALL equal ~bit 5.
REQ-022 Decode: when bits 6 and 4 are clear, segs_n SHALL be the active-low hex glyph of bits 3:0.
REQ-023 Decode: when bit 4 is set and bit 6 is clear, segs_n SHALL be 7'b1111110 (segment g only).
REQ-024 A wr_en write SHALL update shadow[wr_addr] on the next edge; writes SHALL never alter the active bank directly.
REQ-025 An out-of-range wr_addr (>= NUM_DIGITS) SHALL be ignored.
REQ-026 commit SHALL set commit_pending on the next edge; repeated commits while pending SHALL have no further effect.
REQ-027 The frame boundary is the cycle in which the slot counter wraps while digit = NUM_DIGITS-1; at that cycle frame_done SHALL pulse high for exactly one cycle.
REQ-028 At the frame boundary, if commit_pending=1, the entire shadow bank SHALL be copied to the active bank and commit_pending SHALL clear.
REQ-029 A wr_en in the same cycle as the copy SHALL land in shadow only; the active bank SHALL receive the pre-write shadow contents.
REQ-030 A commit in the same cycle as the copy SHALL leave commit_pending set, taking effect at the following boundary.
REQ-031 Digit 0 of the new frame SHALL display the newly copied active contents; no frame SHALL show mixed old and new banks.

Reset
REQ-032 On rst=1, all shadow and active codes SHALL be set to 7'b1000000 (blank).
REQ-033 On rst=1, the slot counter and digit index SHALL be set to 0.
REQ-034 On rst=1, commit_pending and frame_done SHALL be set to 0, an_n to all ones, segs_n to 7'h7F, and dp_n to 1.
REQ-035 A reset asserted mid-slot or with a commit pending SHALL discard the pending commit, with scanning restarting at digit 0, counter 0, on the first cycle after release.

Structure
REQ-036 Package sevenseg_pkg SHALL hold the code bit-position constants BLANK_BIT=6, DP_BIT=5, and DASH_BIT=4.
REQ-037 Package sevenseg_pkg SHALL hold CODE_BLANK=7'b1000000, CODE_DASH=7'b0010000, and the 16-entry hex glyph table.
REQ-038 The decode SHALL be the existing sub-module sevenseg_ext, instantiated once on the registered code.

Verification
REQ-039 With NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2, and all digit_en=1 after reset: an_n SHALL be 4'hF for 2 cycles then 4'hE for 6 cycles, followed by 4'hD, 4'hB, 4'h7, with frame_done pulsing once every 32 cycles.
REQ-040 Write shadow[1]=7'h05 without commit: digit 1 SHALL stay blank (segs_n=7'h7F); after commit, digit 1 SHALL show segs_n=~7'b1011011 starting at the next frame only.
REQ-041 wr_en to shadow[2]=7'h28 in the same cycle as the copy that carries shadow[2]=7'h03: digit 2 SHALL show "3" this frame and "8" with dp_n=0 only after a further commit.
REQ-042 With digit_en=4'b1011: an_n SHALL remain 4'hF throughout slot 2, and the frame period SHALL stay 32 cycles.
REQ-043 Code 7'h10 SHALL give segs_n=7'b1111110; code 7'h7A SHALL give segs_n=7'h7F and dp_n=1.
REQ-044 rst asserted mid-slot-2 with commit_pending=1: on the next cycle an_n=4'hF, commit_pending=0, and all digits SHALL be blank on the next frame.
